// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, LSU state encoding and request legality check
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  // High for an illegal funct3 or an address not aligned to the access size
  function automatic logic is_misaligned(input logic we, input logic [2:0] funct3, input logic [1:0] b);
    logic ill;
    ill = we ? funct3 > 3'd2 : (funct3 == 3'd3 || funct3 > 3'd5);
    return ill || (funct3[1:0] == 2'b01 && b[0]) || (funct3[1:0] == 2'b10 && b != 2'b00);
  endfunction
endpackage

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_port_if: data RAM port bus between the LSU (master) and the RAM (slave)
interface lsu_mem_port_if #(parameter int ADDR_W = 15);
  logic i_mem_valid;
  logic i_mem_ready;
  logic i_mem_we;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [3:0][7:0] i_mem_data;
  logic [3:0] i_mem_mask;
  logic t_mem_valid;
  logic [3:0][7:0] t_mem_data;
  modport master(output i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask,
                 input i_mem_ready, t_mem_valid, t_mem_data);
  modport slave(input i_mem_valid, i_mem_we, i_mem_addr, i_mem_data, i_mem_mask,
                output i_mem_ready, t_mem_valid, t_mem_data);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: byte-lane mask, lane-replicated write data and extended load data
module lsu_align
  import lsu_pkg::*;
(
  input  logic            we,
  input  logic [2:0]      funct3,
  input  logic [1:0]      b,
  input  logic [31:0]     wdata,
  input  logic [3:0][7:0] word,
  output logic [3:0]      mask,
  output logic [3:0][7:0] data,
  output logic [31:0]     rdata
);
  logic [31:0] sh;
  // Lane steering for stores and right-justify plus extend for loads
  always_comb begin
    sh = word >> {b, 3'b000};
    mask = !we ? 4'h0 : funct3[1:0] == 2'b00 ? 4'b0001 << b : funct3[1:0] == 2'b01 ? 4'b0011 << b : 4'hF;
    data = funct3[1:0] == 2'b00 ? {4{wdata[7:0]}} : funct3[1:0] == 2'b01 ? {2{wdata[15:0]}} : wdata;
    rdata = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
            funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
            funct3 == F3_BU ? {24'h0, sh[7:0]} :
            funct3 == F3_HU ? {16'h0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding RISC-V load/store port onto a byte-masked RAM port
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int DEPTH  = 8192,
  parameter int ADDR_W = $clog2(DEPTH) + 2
)
(
  input  logic              clk,
  input  logic              rstf,
  input  logic              t_req_valid,
  output logic              t_req_ready,
  input  logic              t_req_we,
  input  logic [2:0]        t_req_funct3,
  input  logic [ADDR_W-1:0] t_req_addr,
  input  logic [31:0]       t_req_wdata,
  output logic              i_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       i_rsp_rdata,
  output logic              i_rsp_err,
  lsu_mem_port_if.master    mem
);
  state_t state, nxt;
  logic we_q, err, idle;
  logic [2:0] f3_q;
  logic [1:0] b_q;
  logic [3:0] a_mask;
  logic [3:0][7:0] a_data;
  logic [31:0] a_rdata;
  assign idle = state == IDLE;
  assign t_req_ready = idle;
  assign i_rsp_valid = state == RESP;
  assign mem.i_mem_valid = state == REQ;
  assign err = is_misaligned(t_req_we, t_req_funct3, t_req_addr[1:0]);
  lsu_align u_align (
    .we(t_req_we),
    .funct3(idle ? t_req_funct3 : f3_q),
    .b(idle ? t_req_addr[1:0] : b_q),
    .wdata(t_req_wdata),
    .word(mem.t_mem_data),
    .mask(a_mask),
    .data(a_data),
    .rdata(a_rdata)
  );
  // Transaction sequencing: errors skip the RAM, stores skip the read wait
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = t_req_valid ? (err ? RESP : REQ) : IDLE;
      REQ:     nxt = mem.i_mem_ready ? (we_q ? RESP : WAIT) : REQ;
      WAIT:    nxt = mem.t_mem_valid ? RESP : WAIT;
      default: nxt = i_rsp_ready ? IDLE : RESP;
    endcase
  end
  // Capture the request on acceptance and the formatted read word in WAIT
  always_ff @(posedge clk) begin
    if (rstf) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= 3'd0;
      b_q <= 2'd0;
      i_rsp_rdata <= 32'd0;
      i_rsp_err <= 1'b0;
      mem.i_mem_we <= 1'b0;
      mem.i_mem_addr <= '0;
      mem.i_mem_data <= '0;
      mem.i_mem_mask <= 4'd0;
    end else begin
      state <= nxt;
      if (idle && t_req_valid) begin
        we_q <= t_req_we;
        f3_q <= t_req_funct3;
        b_q <= t_req_addr[1:0];
        i_rsp_rdata <= 32'd0;
        i_rsp_err <= err;
        mem.i_mem_we <= t_req_we && !err;
        mem.i_mem_addr <= {t_req_addr[ADDR_W-1:2], 2'b00};
        mem.i_mem_data <= a_data;
        mem.i_mem_mask <= err ? 4'd0 : a_mask;
      end
      if (state == WAIT && mem.t_mem_valid) i_rsp_rdata <= a_rdata;
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed vector table plus backpressure and reset corner sequences
module tb_lsu_mem_port;
  logic clk = 0, rstf = 1;
  logic t_req_valid = 0, t_req_we = 0, i_rsp_ready = 1;
  logic [2:0] t_req_funct3 = 0;
  logic [14:0] t_req_addr = 0;
  logic [31:0] t_req_wdata = 0;
  logic t_req_ready, i_rsp_valid, i_rsp_err;
  logic [31:0] i_rsp_rdata;
  int errors = 0, checks = 0, reqs = 0;
  logic [31:0] ram [0:63] = '{default: 32'h0};

  lsu_mem_port_if #(.ADDR_W(15)) m ();

  lsu_mem_port dut (
    .clk(clk), .rstf(rstf),
    .t_req_valid(t_req_valid), .t_req_ready(t_req_ready), .t_req_we(t_req_we),
    .t_req_funct3(t_req_funct3), .t_req_addr(t_req_addr), .t_req_wdata(t_req_wdata),
    .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata),
    .i_rsp_err(i_rsp_err), .mem(m)
  );

  always #5 clk = ~clk;

  // RAM model: byte-masked writes, one-cycle-latency reads, request counter
  always @(posedge clk) begin
    m.t_mem_valid <= 1'b0;
    if (m.i_mem_valid && m.i_mem_ready) begin
      reqs <= reqs + 1;
      if (m.i_mem_we) begin
        for (int k = 0; k < 4; k++)
          if (m.i_mem_mask[k]) ram[m.i_mem_addr[7:2]][8*k +: 8] <= m.i_mem_data[k];
      end else begin
        m.t_mem_valid <= 1'b1;
        m.t_mem_data <= ram[m.i_mem_addr[7:2]];
      end
    end
  end

  typedef struct {
    logic we; logic [2:0] f3; logic [14:0] addr; logic [31:0] wd;
    logic [31:0] rd; logic err; int lat; logic [3:0] mask; logic [31:0] md;
  } vec_t;
  vec_t v[$];

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [14:0] addr, logic [31:0] wd,
                              logic [31:0] rd, logic err, int lat, logic [3:0] mask, logic [31:0] md);
    vec_t x;
    x.we = we; x.f3 = f3; x.addr = addr; x.wd = wd; x.rd = rd; x.err = err;
    x.lat = lat; x.mask = mask; x.md = md;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [14:0] addr, input logic [31:0] wd,
                     input int mstall, input int rstall,
                     output logic [31:0] rd, output logic er, output int lat, output int nreq,
                     output logic [3:0] mask, output logic [31:0] md, output logic [14:0] maddr,
                     output logic mstab, output logic rstab);
    int cyc, ms, rs, r0;
    logic done, seen_m, seen_r, mwe;
    t_req_we = we; t_req_funct3 = f3; t_req_addr = addr; t_req_wdata = wd; t_req_valid = 1;
    ms = mstall; rs = rstall;
    m.i_mem_ready = ms == 0; i_rsp_ready = rs == 0;
    r0 = reqs; rd = 0; er = 0; lat = 0; mask = 0; md = 0; maddr = 0; mwe = 0;
    mstab = 1; rstab = 1; done = 0; seen_m = 0; seen_r = 0;
    @(posedge clk); #1;
    t_req_valid = 0; cyc = 1;
    while (!done && cyc < 40) begin
      if (m.i_mem_valid) begin
        if (!seen_m) begin
          mask = m.i_mem_mask; md = m.i_mem_data; maddr = m.i_mem_addr; mwe = m.i_mem_we;
        end else if ({mask, md, maddr, mwe} !== {m.i_mem_mask, m.i_mem_data, m.i_mem_addr, m.i_mem_we})
          mstab = 0;
        seen_m = 1;
        if (ms > 0) begin m.i_mem_ready = 0; ms--; end else m.i_mem_ready = 1;
      end
      if (i_rsp_valid) begin
        if (!seen_r) begin lat = cyc; rd = i_rsp_rdata; er = i_rsp_err; end
        else if ({rd, er} !== {i_rsp_rdata, i_rsp_err}) rstab = 0;
        seen_r = 1;
        if (rs > 0) begin i_rsp_ready = 0; rs--; end else begin i_rsp_ready = 1; done = 1; end
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("timeout", {31'd0, done}, 32'd1);
    chk("ready_after", {31'd0, t_req_ready}, 32'd1);
    nreq = reqs - r0;
  endtask

  initial begin
    logic [31:0] rd, md;
    logic er, ms, rsb, seen;
    logic [3:0] mask;
    logic [14:0] maddr;
    int lat, nreq;
    v.push_back(mk(1, 3'b010, 15'h010, 32'hDEADBEEF, 0, 0, 2, 4'hF, 32'hDEADBEEF));
    v.push_back(mk(1, 3'b000, 15'h013, 32'h000000A5, 0, 0, 2, 4'b1000, 32'hA5A5A5A5));
    v.push_back(mk(0, 3'b100, 15'h013, 0, 32'h000000A5, 0, 3, 0, 0));
    v.push_back(mk(0, 3'b000, 15'h013, 0, 32'hFFFFFFA5, 0, 3, 0, 0));
    v.push_back(mk(0, 3'b010, 15'h010, 0, 32'hA5ADBEEF, 0, 3, 0, 0));
    v.push_back(mk(1, 3'b001, 15'h012, 32'h00001234, 0, 0, 2, 4'b1100, 32'h12341234));
    v.push_back(mk(0, 3'b101, 15'h012, 0, 32'h00001234, 0, 3, 0, 0));
    v.push_back(mk(0, 3'b001, 15'h010, 0, 32'hFFFFBEEF, 0, 3, 0, 0));
    v.push_back(mk(1, 3'b010, 15'h020, 32'h80017FFF, 0, 0, 2, 4'hF, 32'h80017FFF));
    v.push_back(mk(0, 3'b001, 15'h022, 0, 32'hFFFF8001, 0, 3, 0, 0));
    v.push_back(mk(0, 3'b101, 15'h022, 0, 32'h00008001, 0, 3, 0, 0));
    v.push_back(mk(0, 3'b001, 15'h020, 0, 32'h00007FFF, 0, 3, 0, 0));
    v.push_back(mk(0, 3'b000, 15'h021, 0, 32'h0000007F, 0, 3, 0, 0));
    v.push_back(mk(0, 3'b000, 15'h023, 0, 32'hFFFFFF80, 0, 3, 0, 0));
    v.push_back(mk(1, 3'b000, 15'h021, 32'h123456C3, 0, 0, 2, 4'b0010, 32'hC3C3C3C3));
    v.push_back(mk(0, 3'b100, 15'h021, 0, 32'h000000C3, 0, 3, 0, 0));
    v.push_back(mk(0, 3'b010, 15'h021, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(0, 3'b001, 15'h023, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 3'b001, 15'h011, 32'h0000FFFF, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 3'b010, 15'h012, 32'hFFFFFFFF, 0, 1, 1, 0, 0));
    v.push_back(mk(0, 3'b011, 15'h020, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(0, 3'b110, 15'h020, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(0, 3'b111, 15'h020, 0, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 3'b100, 15'h020, 32'hFFFFFFFF, 0, 1, 1, 0, 0));
    v.push_back(mk(1, 3'b011, 15'h020, 32'hFFFFFFFF, 0, 1, 1, 0, 0));
    v.push_back(mk(0, 3'b010, 15'h020, 0, 32'h8001C3FF, 0, 3, 0, 0));

    m.i_mem_ready = 1;
    repeat (3) @(posedge clk);
    #1 rstf = 0;
    chk("rst_req_ready", {31'd0, t_req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
    chk("rst_mem_valid", {31'd0, m.i_mem_valid}, 32'd0);
    chk("rst_rsp", {i_rsp_rdata[30:0], i_rsp_err}, 32'd0);
    chk("rst_mem_ctl", {12'd0, m.i_mem_we, m.i_mem_mask, m.i_mem_addr}, 32'd0);
    chk("rst_mem_data", m.i_mem_data, 32'd0);

    for (int i = 0; i < v.size(); i++) begin
      run(v[i].we, v[i].f3, v[i].addr, v[i].wd, 0, 0, rd, er, lat, nreq, mask, md, maddr, ms, rsb);
      chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
      chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, v[i].err});
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_reqs", i), nreq, v[i].err ? 0 : 1);
      if (!v[i].err) begin
        chk($sformatf("v%0d_mask", i), {28'd0, mask}, {28'd0, v[i].mask});
        chk($sformatf("v%0d_mdata", i), md, v[i].md);
        chk($sformatf("v%0d_maddr", i), {17'd0, maddr}, {17'd0, v[i].addr & 15'h7FFC});
      end
    end

    run(0, 3'b010, 15'h020, 0, 3, 2, rd, er, lat, nreq, mask, md, maddr, ms, rsb);
    chk("bp_rdata", rd, 32'h8001C3FF);
    chk("bp_err", {31'd0, er}, 32'd0);
    chk("bp_reqs", nreq, 1);
    chk("bp_mem_stable", {31'd0, ms}, 32'd1);
    chk("bp_rsp_stable", {31'd0, rsb}, 32'd1);
    chk("bp_lat", lat, 6);

    run(1, 3'b001, 15'h02E, 32'h0000BEEF, 2, 1, rd, er, lat, nreq, mask, md, maddr, ms, rsb);
    chk("bps_mask", {28'd0, mask}, 32'h0000000C);
    chk("bps_mdata", md, 32'hBEEFBEEF);
    chk("bps_reqs", nreq, 1);
    chk("bps_stable", {30'd0, ms, rsb}, 32'd3);

    t_req_we = 0; t_req_funct3 = 3'b010; t_req_addr = 15'h020; t_req_valid = 1;
    m.i_mem_ready = 1; i_rsp_ready = 1;
    @(posedge clk); #1;
    t_req_valid = 0;
    chk("rw_in_req", {31'd0, m.i_mem_valid}, 32'd1);
    @(posedge clk); #1;
    chk("rw_rvalid", {31'd0, m.t_mem_valid}, 32'd1);
    rstf = 1;
    @(posedge clk); #1;
    rstf = 0;
    chk("rw_rsp_zero", {i_rsp_rdata[30:0], i_rsp_err}, 32'd0);
    chk("rw_rdata_zero", i_rsp_rdata, 32'd0);
    chk("rw_mem_zero", {12'd0, m.i_mem_we, m.i_mem_mask, m.i_mem_addr}, 32'd0);
    chk("rw_ready", {31'd0, t_req_ready}, 32'd1);
    seen = 0;
    repeat (6) begin
      if (i_rsp_valid || m.i_mem_valid) seen = 1;
      @(posedge clk); #1;
    end
    chk("rw_no_rsp", {31'd0, seen}, 32'd0);

    run(0, 3'b100, 15'h021, 0, 0, 0, rd, er, lat, nreq, mask, md, maddr, ms, rsb);
    chk("post_rst_rdata", rd, 32'h000000C3);
    chk("post_rst_lat", lat, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
